// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative HI/LO multiply/divide unit.
// Multiply is shift-add, divide is restoring shift-subtract, one bit per
// cycle for WIDTH cycles. Optional build macro MULDIV_SIGNED_EN turns MULT and
// DIV (op 00 / 10) into signed operations; without it they equal MULTU/DIVU.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             op_div;

  // Iteration registers: multiply keeps {partial product, multiplier},
  // divide keeps {partial remainder, dividend/quotient}; opnd is the
  // multiplicand or divisor.
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opnd;

  logic             accept;
  logic             zero_div;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] nxt_hi;
  logic [WIDTH-1:0] nxt_lo;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  assign accept   = start && (state != RUN);
  assign zero_div = op[1] && (b == '0);
  assign stall    = busy | (start & (state != RUN));

`ifdef MULDIV_SIGNED_EN
  logic sign_a;
  logic sign_b;
  logic neg_q;
  logic neg_r;

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
    if (v < 0) magnitude = -v;
    else       magnitude = v;
  endfunction

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    negate = (~v) + WIDTH'(1);
  endfunction

  function automatic logic [2*WIDTH-1:0] negate2(input logic [2*WIDTH-1:0] v);
    negate2 = (~v) + (2*WIDTH)'(1);
  endfunction

  // Signed ops work on magnitudes; the sign is restored on the final step.
  always_comb begin
    sign_a = ~op[0] & a[WIDTH-1];
    sign_b = ~op[0] & b[WIDTH-1];
    a_mag  = sign_a ? magnitude(a) : a;
    b_mag  = sign_b ? magnitude(b) : b;
  end

  // Apply quotient/product sign and remainder sign to the last iteration.
  always_comb begin
    res_hi = nxt_hi;
    res_lo = nxt_lo;
    if (op_div) begin
      if (neg_q) res_lo = negate(nxt_lo);
      if (neg_r) res_hi = negate(nxt_hi);
    end else if (neg_q) begin
      {res_hi, res_lo} = negate2({nxt_hi, nxt_lo});
    end
  end

  // Result sign flags captured with the operands.
  always_ff @(posedge clk) begin
    if (accept) begin
      neg_q <= sign_a ^ sign_b;
      neg_r <= sign_a;
    end
  end
`else
  // MULT and MULTU (and DIV and DIVU) are the same operation in this build.
  logic unused_op0;
  assign unused_op0 = op[0];
  assign a_mag      = a;
  assign b_mag      = b;
  assign res_hi     = nxt_hi;
  assign res_lo     = nxt_lo;
`endif

  // One shift-add or restoring shift-subtract step on the iteration registers.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    if (op_div) begin
      nxt_hi = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
      nxt_lo = {acc_lo[WIDTH-2:0], ~div_diff[WIDTH]};
    end else begin
      nxt_hi = mul_sum[WIDTH:1];
      nxt_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  // Iteration datapath: load operands on accept, step once per RUN cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      acc_hi <= '0;
      if (op[1]) begin
        acc_lo <= a_mag;
        opnd   <= b_mag;
      end else begin
        acc_lo <= b_mag;
        opnd   <= a_mag;
      end
    end else if (state == RUN) begin
      acc_hi <= nxt_hi;
      acc_lo <= nxt_lo;
    end
  end

  // Control FSM with registered busy/done and the architectural HI/LO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      op_div   <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      busy <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE, FIN: begin
          if (start) begin
            op_div <= op[1];
            cnt    <= '0;
            if (zero_div) begin
              state    <= FIN;
              done     <= 1'b1;
              hi       <= a;
              lo       <= '1;
              div_zero <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            state <= FIN;
            done  <= 1'b1;
            hi    <= res_hi;
            lo    <= res_lo;
            if (op_div) div_zero <= 1'b0;
          end else begin
            busy <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed bench for muldiv_unit with a result scoreboard.
`timescale 1ns/1ps
module tb_muldiv_unit;
  localparam int W  = 32;
  localparam int CK = 2*W + 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         stall;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         div_zero;

  int           total = 0;
  int           bad   = 0;
  logic [CK-1:0] sb_q[$];
  logic [CK-1:0] exp_v;
  logic [CK-1:0] last_exp = '0;
  logic [CK-1:0] mon_v;
  logic          cur_dz = 1'b0;
  logic [2*W-1:0] hold_exp;
  int            ndone;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo),
    .div_zero(div_zero)
  );

  task automatic chk(input string tag, input logic [CK-1:0] obs, input logic [CK-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: {div_zero, hi, lo} computed with native wide arithmetic.
  function automatic logic [CK-1:0] model(input logic [1:0] o, input logic [W-1:0] x,
                                          input logic [W-1:0] y, input logic dz);
    logic [2*W-1:0] p;
    longint sx, sy, q, r;
    logic sgn;
`ifdef MULDIV_SIGNED_EN
    sgn = ~o[0];
`else
    sgn = 1'b0;
`endif
    if (!o[1]) begin
      if (sgn) p = 64'(longint'($signed(x)) * longint'($signed(y)));
      else     p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
      return {dz, p};
    end
    if (y == '0) return {1'b1, x, {W{1'b1}}};
    if (sgn) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
    end else begin
      sx = longint'({{W{1'b0}}, x});
      sy = longint'({{W{1'b0}}, y});
    end
    q = sx / sy;
    r = sx % sy;
    return {1'b0, r[W-1:0], q[W-1:0]};
  endfunction

  // Scoreboard: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      chk("sb_pending", CK'(sb_q.size() != 0), CK'(1));
      if (sb_q.size() != 0) begin
        mon_v = sb_q.pop_front();
        chk("result", {div_zero, hi, lo}, mon_v);
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit track);
    op = o; a = x; b = y; start = 1'b1;
    if (track) begin
      exp_v = model(o, x, y, cur_dz);
      sb_q.push_back(exp_v);
      cur_dz   = exp_v[CK-1];
      last_exp = exp_v;
    end
  endtask

  task automatic release_start();
    start = 1'b0;
    op    = 2'($urandom);
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic wait_done(input string tag, input int lat);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 100);
    chk({tag, "_latency"}, CK'(n), CK'(lat));
  endtask

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input string tag);
    issue(o, x, y, 1'b1);
    @(posedge clk); #1;
    release_start();
    wait_done(tag, (o[1] && y == '0) ? 1 : W + 1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ctrl", CK'({busy, done, stall, div_zero}), CK'(0));
    chk("rst_hilo", CK'({hi, lo}), CK'(0));

    // MULTU 7*6 with cycle-by-cycle handshake checks
    issue(2'b01, 32'd7, 32'd6, 1'b1);
    #1;
    chk("accept_stall", CK'({busy, stall}), CK'(2'b01));
    @(posedge clk); #1;
    release_start();
    for (int k = 1; k <= W; k++) begin
      @(negedge clk);
      chk("run_flags", CK'({busy, stall, done}), CK'(3'b110));
    end
    @(negedge clk);
    chk("fin_flags", CK'({busy, stall, done}), CK'(3'b001));
    chk("multu_7x6", CK'({div_zero, hi, lo}), {1'b0, 32'd0, 32'd42});

    run_op(2'b01, '1, '1, "multu_max");
    chk("multu_max_hilo", CK'({hi, lo}), CK'(64'hFFFFFFFE_00000001));

    run_op(2'b11, 32'd100, 32'd7, "divu_100_7");
    chk("divu_100_7_res", {div_zero, hi, lo}, {1'b0, 32'd2, 32'd14});
    run_op(2'b11, 32'd5, 32'd0, "divu_by_zero");
    chk("divu_by_zero_res", {div_zero, hi, lo}, {1'b1, 32'd5, 32'hFFFFFFFF});
    run_op(2'b01, 32'd3, 32'd3, "multu_keeps_dz");
    chk("multu_keeps_dz_res", {div_zero, hi, lo}, {1'b1, 32'd0, 32'd9});

    run_op(2'b10, 32'hFFFFFFF9, 32'd2, "div_m7_2");
`ifdef MULDIV_SIGNED_EN
    chk("div_m7_2_res", {div_zero, hi, lo}, {1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD});
`else
    chk("div_m7_2_res", {div_zero, hi, lo}, {1'b0, 32'd1, 32'h7FFFFFFC});
`endif
    run_op(2'b00, 32'hFFFFFFFD, 32'd4, "mult_m3_4");
`ifdef MULDIV_SIGNED_EN
    chk("mult_m3_4_res", CK'({hi, lo}), CK'(64'hFFFFFFFF_FFFFFFF4));
`else
    chk("mult_m3_4_res", CK'({hi, lo}), CK'(64'h00000003_FFFFFFF4));
`endif
    run_op(2'b10, 32'h80000000, 32'd0, "div_by_zero");
    chk("div_by_zero_res", {div_zero, hi, lo}, {1'b1, 32'h80000000, 32'hFFFFFFFF});

    for (int i = 0; i < 6; i++) begin
      run_op(2'($urandom), $urandom, $urandom, "random");
    end

    // Start during RUN is ignored and HI/LO hold; then back-to-back from FIN
    hold_exp = last_exp[2*W-1:0];
    issue(2'b01, 32'd1000, 32'd3000, 1'b1);
    @(posedge clk); #1;
    release_start();
    repeat (5) @(negedge clk);
    issue(2'b11, 32'd77, 32'd0, 1'b0);
    @(posedge clk); #1;
    release_start();
    @(negedge clk);
    chk("ignored_start_busy", CK'(busy), CK'(1));
    chk("hold_hilo", CK'({hi, lo}), CK'(hold_exp));
    wait_done("b2b_first", W + 1 - 6);
    chk("b2b_first_res", CK'({hi, lo}), CK'(64'd3000000));
    issue(2'b01, 32'hDEAD, 32'hBEEF, 1'b1);
    @(posedge clk); #1;
    release_start();
    @(negedge clk);
    chk("b2b_no_bubble", CK'({busy, done}), CK'(2'b10));
    wait_done("b2b_second", W);

    // Reset at RUN iteration 10 aborts without a done pulse
    issue(2'b01, 32'h1234, 32'h5678, 1'b0);
    @(posedge clk); #1;
    release_start();
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cur_dz = 1'b0;
    @(negedge clk);
    chk("abort_ctrl", CK'({busy, done, stall, div_zero}), CK'(0));
    chk("abort_hilo", CK'({hi, lo}), CK'(0));
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", CK'(ndone), CK'(0));
    run_op(2'b01, 32'd5, 32'd5, "after_abort");
    chk("after_abort_res", {div_zero, hi, lo}, {1'b0, 32'd0, 32'd25});

    @(negedge clk);
    chk("sb_empty", CK'(sb_q.size()), CK'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
